// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core; FETCH/DECODE/EXEC/MEM/WB state machine
// sharing one ALU and register file between separate instruction and data memories.
module multi_cycle_cpu #(
   parameter int              IMEM_DEPTH = 64,
   parameter int              DMEM_DEPTH = 64,
   parameter int              PC_W       = 16,
   parameter logic [PC_W-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [31:0]                   imem_wdata,
   input  logic [4:0]                    dbg_addr,
   output logic [31:0]                   dbg_data,
   output logic [PC_W-1:0]               pc,
   output logic                          retire,
   output logic                          halted,
   output logic                          illegal
);
   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                          OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22,
                          FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t          r_state, w_next;
   logic [31:0]     r_imem [IMEM_DEPTH];
   logic [31:0]     r_dmem [DMEM_DEPTH];
   logic [31:0]     r_rf [32];
   logic [PC_W-1:0] r_pc, w_pc4, w_pc_next, w_br, w_jt;
   logic [31:0]     r_ir, r_a, r_b, r_alu, r_mdr, w_alu, w_simm, w_zimm;
   logic [5:0]      w_op, w_fn;
   logic [4:0]      w_rs, w_rt, w_rd, w_sa, w_dst;
   logic            r_illegal, w_valid, w_is_br, w_is_j, w_is_lw, w_is_sw, w_taken;

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_sa    = r_ir[10:6];
   assign w_fn    = r_ir[5:0];
   assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_zimm  = {16'h0, r_ir[15:0]};
   assign w_is_br = w_op == OP_BEQ || w_op == OP_BNE;
   assign w_is_j  = w_op == OP_J;
   assign w_is_lw = w_op == OP_LW;
   assign w_is_sw = w_op == OP_SW;
   assign w_taken = (w_op == OP_BEQ) ? r_a == r_b : r_a != r_b;
   assign w_dst   = (w_op == OP_R) ? w_rd : w_rt;
   assign w_valid = (w_op == OP_R) ? w_fn inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}
                                   : w_op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI,
                                                  OP_ORI, OP_LW, OP_SW};
   assign w_pc4   = r_pc + PC_W'(4);
   assign w_br    = w_pc4 + PC_W'(w_simm << 2);
   // upper nibble of PC+4 survives a jump only when PC_W reaches past bit 27
   assign w_jt    = PC_W'({4'(32'(w_pc4) >> 28), r_ir[25:0], 2'b00});

   assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : r_rf[dbg_addr];
   assign pc       = r_pc;
   assign halted   = r_state == S_HALT;
   assign illegal  = r_illegal;

   always_comb begin
      w_alu = r_a + w_simm;
      if (w_op == OP_R)
         case (w_fn)
            FN_SUB:  w_alu = r_a - r_b;
            FN_AND:  w_alu = r_a & r_b;
            FN_OR:   w_alu = r_a | r_b;
            FN_SLT:  w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
            FN_SLL:  w_alu = r_b << w_sa;
            FN_SRL:  w_alu = r_b >> w_sa;
            default: w_alu = r_a + r_b;
         endcase
      else if (w_op == OP_SLTI) w_alu = {31'b0, $signed(r_a) < $signed(w_simm)};
      else if (w_op == OP_ANDI) w_alu = r_a & w_zimm;
      else if (w_op == OP_ORI)  w_alu = r_a | w_zimm;
   end

   always_comb begin
      w_next    = r_state;
      retire    = 1'b0;
      w_pc_next = w_pc4;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = (w_op == OP_HALT || !w_valid) ? S_HALT : S_EXEC;
         S_EXEC: begin
            retire    = w_is_br || w_is_j;
            w_next    = retire ? S_FETCH : (w_is_lw || w_is_sw) ? S_MEM : S_WB;
            w_pc_next = w_is_j ? w_jt : (w_is_br && w_taken) ? w_br : w_pc4;
         end
         S_MEM: begin
            retire = w_is_sw;
            w_next = w_is_sw ? S_FETCH : S_WB;
         end
         S_WB: begin
            retire = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_illegal <= 1'b0;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu     <= '0;
         r_mdr     <= '0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         if (r_state == S_FETCH) r_ir <= r_imem[r_pc[IW+1:2]];
         if (r_state == S_DECODE) begin
            r_a       <= r_rf[w_rs];
            r_b       <= r_rf[w_rt];
            r_illegal <= !w_valid && w_op != OP_HALT;
         end
         if (r_state == S_EXEC) r_alu <= w_alu;
         if (r_state == S_MEM) r_mdr <= r_dmem[r_alu[DW+1:2]];
         if (r_state == S_WB && w_dst != 5'd0) r_rf[w_dst] <= w_is_lw ? r_mdr : r_alu;
         if (retire) r_pc <= w_pc_next;
      end
   end

   // memories keep their contents across reset; imem is loadable only while the core is idle
   always_ff @(posedge clk) begin
      if (imem_we && (rst || halted)) r_imem[imem_addr] <= imem_wdata;
      if (!rst && r_state == S_MEM && w_is_sw) r_dmem[r_alu[DW+1:2]] <= r_b;
   end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed programs for multi_cycle_cpu with hand-computed results,
// per-edge retire/halt masks and PC logs.
module tb_multi_cycle_cpu;
   localparam int PC_W = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_we = 1'b0;
   logic [3:0]      imem_addr = '0;
   logic [31:0]     imem_wdata = '0;
   logic [4:0]      dbg_addr = '0;
   logic [31:0]     dbg_data;
   logic [PC_W-1:0] pc;
   logic            retire, halted, illegal;

   int              n_pass = 0, n_chk = 0, n_ret;
   logic [31:0]     prog [16];
   logic [31:0]     ret_m, hlt_m;
   logic [PC_W-1:0] pc_log [32];

   multi_cycle_cpu #(.IMEM_DEPTH(16), .DMEM_DEPTH(64), .PC_W(PC_W), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .retire(retire), .halted(halted),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input int sa, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
   endfunction

   function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] f_j(input int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
      dbg_addr = 5'(r);
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic clr_prog();
      for (int i = 0; i < 16; i++) prog[i] = 32'h0;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      imem_we    = 1'b1;
      imem_addr  = 4'(a);
      imem_wdata = d;
      tick();
      imem_we    = 1'b0;
   endtask

   // loads prog with rst held; the core stays in reset until go()
   task automatic boot();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) wr(i, prog[i]);
   endtask

   task automatic go();
      rst = 1'b0;
   endtask

   // bit k of ret_m: retire high in the cycle ending at edge k; hlt_m/pc_log: state after edge k
   task automatic run(input int n);
      ret_m = '0;
      hlt_m = '0;
      for (int k = 1; k <= n; k++) begin
         ret_m[k]  = retire;
         tick();
         hlt_m[k]  = halted;
         pc_log[k] = pc;
      end
   endtask

   task automatic run_to_halt(input string tag, input int max);
      int e = 0;
      n_ret = 0;
      while (!halted && e < max) begin
         if (retire) n_ret++;
         tick();
         e++;
      end
      chk(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      // addi r1,r0,5; add r2,r1,r1; halt
      clr_prog();
      prog[0] = f_i('h08, 0, 1, 5);
      prog[1] = f_r(1, 1, 2, 0, 'h20);
      prog[2] = 32'hFC000000;
      tick();
      boot();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_retire", 32'(retire), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      go();
      run(10);
      chk("t1_retire_mask", ret_m, 32'h0000_0110);
      chk("t1_halt_mask", hlt_m, 32'h0000_0400);
      chk("t1_illegal", 32'(illegal), 32'h0);
      chk("t1_pc", 32'(pc), 32'h8);
      chk_reg("t1_r1", 1, 32'd5);
      chk_reg("t1_r2", 2, 32'd10);

      // build 0xDEADBEEF, store then load it back
      clr_prog();
      prog[0] = f_i('h0D, 0, 1, 'hDEAD);
      prog[1] = f_r(0, 1, 1, 16, 'h00);
      prog[2] = f_i('h0D, 1, 1, 'hBEEF);
      prog[3] = f_i('h2B, 0, 1, 4);
      prog[4] = f_i('h23, 0, 3, 4);
      prog[5] = 32'hFC000000;
      boot();
      chk_reg("rst_clears_r2", 2, 32'h0);
      go();
      run(23);
      chk("t2_retire_mask", ret_m, 32'h0021_1110);
      chk("t2_halt_mask", hlt_m, 32'h0080_0000);
      chk("t2_pc_after_lw", 32'(pc_log[21]), 32'd20);
      chk_reg("t2_r1", 1, 32'hDEADBEEF);
      chk_reg("t2_r3", 3, 32'hDEADBEEF);

      // ALU coverage
      clr_prog();
      prog[0]  = f_i('h08, 0, 1, -3);
      prog[1]  = f_i('h08, 0, 2, 7);
      prog[2]  = f_r(1, 2, 3, 0, 'h22);
      prog[3]  = f_r(1, 2, 4, 0, 'h2A);
      prog[4]  = f_r(2, 1, 5, 0, 'h2A);
      prog[5]  = f_r(1, 2, 6, 0, 'h24);
      prog[6]  = f_r(1, 2, 7, 0, 'h25);
      prog[7]  = f_r(0, 1, 8, 28, 'h02);
      prog[8]  = f_i('h0A, 1, 9, -2);
      prog[9]  = f_i('h0C, 1, 10, 'hFFFF);
      prog[10] = f_i('h08, 0, 0, 7);
      prog[11] = 32'hFC000000;
      boot();
      go();
      run_to_halt("t3_halted", 100);
      chk("t3_retires", 32'(n_ret), 32'd11);
      chk("t3_pc", 32'(pc), 32'd44);
      chk_reg("t3_r1", 1, 32'hFFFFFFFD);
      chk_reg("t3_sub", 3, 32'hFFFFFFF6);
      chk_reg("t3_slt_t", 4, 32'd1);
      chk_reg("t3_slt_f", 5, 32'd0);
      chk_reg("t3_and", 6, 32'd5);
      chk_reg("t3_or", 7, 32'hFFFFFFFF);
      chk_reg("t3_srl", 8, 32'hF);
      chk_reg("t3_slti", 9, 32'd1);
      chk_reg("t3_andi", 10, 32'h0000FFFD);
      chk_reg("t3_r0", 0, 32'h0);

      // branches and jumps
      clr_prog();
      prog[0] = f_i('h04, 0, 0, 2);
      prog[1] = f_j(9);
      prog[2] = f_i('h08, 0, 1, 1);
      prog[3] = f_i('h05, 0, 0, 5);
      prog[4] = f_j(8);
      prog[5] = f_i('h08, 0, 1, 1);
      prog[6] = f_i('h08, 0, 1, 1);
      prog[7] = f_i('h08, 0, 1, 1);
      prog[8] = f_j(1);
      prog[9] = 32'hFC000000;
      boot();
      go();
      run(17);
      chk("t4_retire_mask", ret_m, 32'h0000_9248);
      chk("t4_halt_mask", hlt_m, 32'h0002_0000);
      chk("t4_pc_hold", 32'(pc_log[2]), 32'd0);
      chk("t4_beq_taken", 32'(pc_log[3]), 32'd12);
      chk("t4_bne_not", 32'(pc_log[6]), 32'd16);
      chk("t4_j_fwd", 32'(pc_log[9]), 32'd32);
      chk("t4_j_back", 32'(pc_log[12]), 32'd4);
      chk("t4_j_to_halt", 32'(pc_log[15]), 32'd36);
      chk_reg("t4_r1", 1, 32'h0);

      // PC index wrap past the end of a 16-word imem, nop retires
      clr_prog();
      prog[0]  = f_i('h05, 1, 0, 1);
      prog[1]  = f_j(14);
      prog[2]  = 32'hFC000000;
      prog[14] = f_i('h08, 0, 1, 1);
      prog[15] = 32'h0;
      boot();
      go();
      run(19);
      chk("t5_retire_mask", ret_m, 32'h0002_4448);
      chk("t5_halt_mask", hlt_m, 32'h0008_0000);
      chk("t5_pc_wrap", 32'(pc_log[14]), 32'h40);
      chk("t5_bne_taken", 32'(pc_log[17]), 32'h48);

      // illegal opcode; imem writes gated by run state
      clr_prog();
      prog[0] = f_i('h08, 0, 1, 3);
      prog[1] = 32'hF8000000;
      boot();
      chk_reg("t6_rst_r1", 1, 32'h0);
      go();
      wr(1, f_i('h08, 0, 2, 9));
      run_to_halt("t6_halted", 50);
      chk("t6_illegal", 32'(illegal), 32'd1);
      chk("t6_retires", 32'(n_ret), 32'd1);
      chk("t6_pc", 32'(pc), 32'd4);
      chk_reg("t6_r1", 1, 32'd3);
      chk_reg("t6_r2", 2, 32'h0);
      wr(1, f_i('h08, 0, 2, 9));
      rst = 1'b1;
      wr(2, 32'hFC000000);
      chk("t6_rst_illegal", 32'(illegal), 32'd0);
      chk("t6_rst_halted", 32'(halted), 32'd0);
      go();
      run_to_halt("t6b_halted", 50);
      chk("t6b_illegal", 32'(illegal), 32'd0);
      chk("t6b_retires", 32'(n_ret), 32'd2);
      chk_reg("t6b_r2", 2, 32'd9);

      // unknown R-type funct
      clr_prog();
      prog[0] = f_r(1, 2, 3, 0, 'h3F);
      boot();
      go();
      run(3);
      chk("t7_halt_mask", hlt_m, 32'h0000_000C);
      chk("t7_retire_mask", ret_m, 32'h0);
      chk("t7_illegal", 32'(illegal), 32'd1);

      // reset during sw MEM: store must not land
      clr_prog();
      prog[0] = f_i('h08, 0, 1, 'h55);
      prog[1] = f_i('h2B, 0, 1, 4);
      prog[2] = 32'hFC000000;
      boot();
      go();
      run(7);
      rst = 1'b1;
      tick();
      chk("t8_sw_abort_pc", 32'(pc), 32'h0);
      chk_reg("t8_sw_abort_r1", 1, 32'h0);
      // reset during lw MEM, then full lw sees the untouched word
      clr_prog();
      prog[0] = f_i('h23, 0, 3, 4);
      prog[1] = 32'hFC000000;
      boot();
      go();
      run(3);
      rst = 1'b1;
      tick();
      chk("t8_lw_abort_pc", 32'(pc), 32'h0);
      chk_reg("t8_lw_abort_r3", 3, 32'h0);
      go();
      run(7);
      chk("t8_lw_retire_mask", ret_m, 32'h0000_0020);
      chk("t8_lw_halt_mask", hlt_m, 32'h0000_0080);
      chk_reg("t8_lw_r3", 3, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/multi_cycle_cpu.md
# multi_cycle_cpu

Parametrised multi-cycle MIPS-subset processor: each instruction is executed over 3–5 clock cycles by a central state machine, with instruction and data memories, register file and ALU shared across cycles. It replaces the single-cycle core as the project's CPU top. It adds synchronous reset, a bench-loadable instruction memory, halt/illegal-opcode detection and a retire strobe for scoreboard checking.

## Interface
- `IMEM_DEPTH`, 64: instruction words, power of two
- `DMEM_DEPTH`, 64: data words, power of two
- `PC_W`, 16: PC width in bits, byte address, ≥ log2(IMEM_DEPTH)+2
- `RESET_PC`, 0: PC value loaded on reset, word aligned
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `imem_we` in 1: instruction-memory write enable
- `imem_addr` in log2(IMEM_DEPTH): word index
- `imem_wdata` in 32: instruction word
- `dbg_addr` in 5: register-file debug read index
- `dbg_data` out 32: combinational read of reg[dbg_addr]; 0 for index 0
- `pc` out PC_W: current PC
- `retire` out 1: one-cycle pulse in the last cycle of each completed instruction
- `halted` out 1: core in HALT state
- `illegal` out 1: HALT entered because of an unknown opcode/funct

## Operation
- ISA, fixed 32-bit MIPS encoding:
  - R-type add/sub/and/or/slt (funct 20/22/24/25/2A) and sll/srl (00/02, shift rt by sa).
  - addi/slti (sign-extended immediate); andi/ori (zero-extended immediate).
  - lw/sw: address = rs + sext(imm), byte address; word index = bits [log2(DMEM_DEPTH)+1:2], wraps modulo depth.
  - beq/bne; j (op 02); halt = op 3F.
- Word 0x00000000 (sll r0) is a nop and retires normally.
- Register 0 always reads 0; writes to it are discarded.
- Arithmetic is 32-bit wrap-around with no overflow trap; slt/slti compare signed.
- States and transitions:
  - FETCH: IR ← imem[pc[log2(IMEM_DEPTH)+1:2]], PC index wraps; → DECODE.
  - DECODE: A ← rs, B ← rt, immediate extended; halt → HALT; unknown op/funct → HALT with illegal=1; otherwise → EXEC.
  - EXEC:
    - ALU ops compute ALUOut → WB.
    - lw/sw compute address → MEM.
    - beq/bne: PC ← PC+4+(sext(imm)<<2) if taken, else PC+4; retire; → FETCH.
    - j: PC ← {(PC+4)[PC_W-1:28 if present], target, 2'b00}, truncated to PC_W; retire; → FETCH.
  - MEM: sw writes dmem, PC ← PC+4, retire, → FETCH; lw captures MDR → WB.
  - WB: write rd (R-type) or rt (I-type/lw); PC ← PC+4; retire; → FETCH.
  - HALT: terminal; only rst leaves it.
- imem writes are accepted only while rst=1 or halted=1, and are ignored otherwise.

## Timing
- Cycles per instruction: branch/j 3; R-type, I-ALU and sw 4; lw 5; halt/illegal 2 (FETCH, DECODE), then HALT.
- `retire` is high for exactly one cycle per completed instruction and never for halt or illegal.
- Register-file and dmem writes commit on the rising edge that ends WB or MEM respectively.
- Reset, taking effect on the next rising edge with rst=1 regardless of state:
  - state=FETCH, pc=RESET_PC, retire=0, halted=0, illegal=0, all registers=0.
  - dmem and imem contents are preserved.
- rst asserted mid-instruction aborts it; no partial register/memory write occurs on that edge.
- `dbg_data` and `pc` are valid in every cycle; `pc` changes only on retire edges and on reset.

## Test plan
- Load addi r1,r0,5; add r2,r1,r1; halt. Release rst → retire pulses at cycles 4 and 8 after release; reg2=10; halted=1 at cycle 10; illegal=0.
- sw r1,4(r0) then lw r3,4(r0), with r1=0xDEADBEEF → reg3=0xDEADBEEF; lw takes 5 cycles.
- beq r0,r0,+2 at PC 0 → next fetch at PC 12. bne r0,r0 → next fetch at PC+4. Each branch takes 3 cycles.
- j target=1 from PC 0x20 → PC=4. With IMEM_DEPTH=16, PC 0x40 fetches word 0 (wrap).
- Opcode 0x3E → halted=1, illegal=1, no register change. An imem write while running is ignored; the same write during rst takes effect.
- addi r0,r0,7 → dbg_data(0)=0. rst pulsed during lw's MEM cycle → rt unchanged, pc=RESET_PC.
